// File: rtl/sram_controller.sv
// Bridges a single-cycle MEM-stage word request onto a 16-bit asynchronous SRAM,
// splitting each 32-bit word into low and high half-word accesses.
module sram_controller #(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] sram_dq,
  output logic [17:0] sram_addr,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [3:0]  wait_cnt;
  logic [16:0] idx;
  logic [31:0] wdata;
  logic        is_wr;
  logic [15:0] rd_low;
  logic [31:0] offset;
  logic        in_xfer;
  logic        last_wait;
  logic        accept;
  logic        dq_oe;
  logic [15:0] dq_out;

  assign offset    = address - BASE_ADDR;
  assign in_xfer   = (state == LOW) || (state == HIGH);
  assign last_wait = (wait_cnt == LAST);
  assign accept    = (state == IDLE) && (wr_en || rd_en);

  always_comb begin
    state_next = state;
    ready      = 1'b1;
    case (state)
      IDLE: begin
        if (wr_en || rd_en) begin
          ready      = 1'b0;
          state_next = LOW;
        end
      end
      LOW: begin
        ready = 1'b0;
        if (last_wait) state_next = HIGH;
      end
      HIGH: begin
        ready = 1'b0;
        if (last_wait) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sram_addr = '0;
    if (state == LOW)  sram_addr = {idx, 1'b0};
    if (state == HIGH) sram_addr = {idx, 1'b1};
  end

  // Strobe rises on the last wait cycle of each half so the SRAM latches
  // while data is still held on the bus.
  assign dq_oe     = in_xfer && is_wr;
  assign dq_out    = (state == HIGH) ? wdata[31:16] : wdata[15:0];
  assign sram_we_n = !(dq_oe && !last_wait);
  assign sram_dq   = dq_oe ? dq_out : 16'bz;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      is_wr     <= 1'b0;
      read_data <= '0;
    end else begin
      state <= state_next;
      if ((state_next != state) || !in_xfer) wait_cnt <= '0;
      else                                   wait_cnt <= wait_cnt + 4'd1;
      if (accept) is_wr <= wr_en;
      if ((state == HIGH) && last_wait && !is_wr) read_data <= {sram_dq, rd_low};
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      idx   <= 17'(offset >> 2);
      wdata <= write_data;
    end
    if ((state == LOW) && last_wait && !is_wr) rd_low <= sram_dq;
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: a WAIT_CYCLES=2 instance backed by a small
// SRAM model and a WAIT_CYCLES=1 instance backed by a pattern ROM.
module tb_sram_controller;

  localparam int W  = 2;
  localparam int W1 = 1;

  logic        clk;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n;

  logic        wr_en1, rd_en1;
  logic [31:0] address1, write_data1;
  logic [31:0] read_data1;
  logic        ready1;
  wire  [15:0] sram_dq1;
  logic [17:0] sram_addr1;
  logic        sram_we_n1;

  int cmp   = 0;
  int fails = 0;

  logic        write_phase = 1'b0;
  logic        read_phase  = 1'b0;
  logic        read_phase1 = 1'b0;
  logic [15:0] mem [0:255];
  logic [15:0] model_val;
  logic        prev_we = 1'b1;

  sram_controller #(.WAIT_CYCLES(W), .BASE_ADDR(32'd1024)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_dq(sram_dq), .sram_addr(sram_addr), .sram_we_n(sram_we_n)
  );

  sram_controller #(.WAIT_CYCLES(W1), .BASE_ADDR(32'd1024)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .rd_en(rd_en1), .address(address1),
    .write_data(write_data1), .read_data(read_data1), .ready(ready1),
    .sram_dq(sram_dq1), .sram_addr(sram_addr1), .sram_we_n(sram_we_n1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Async SRAM: latches on the rising edge of the write strobe. Outside writes
  // the bench drives the bus (memory data on reads, 0 otherwise) so a
  // controller that fails to release it shows up as a corrupted value.
  always @(sram_we_n) begin
    if (sram_we_n === 1'b1 && prev_we === 1'b0) mem[sram_addr[7:0]] = sram_dq;
    prev_we = sram_we_n;
  end
  always_comb model_val = read_phase ? mem[sram_addr[7:0]] : 16'h0000;
  assign sram_dq  = write_phase ? 16'bz : model_val;
  assign sram_dq1 = read_phase1 ? (16'hA000 | {4'h0, sram_addr1[11:0]}) : 16'bz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic wr, input logic rd, input logic [31:0] a,
                        input logic [31:0] d, input logic hold,
                        input logic [31:0] exp_rd, input string tag);
    int          low;
    int          half;
    int          pos;
    logic [31:0] off;
    logic [16:0] idx;
    off = a - 32'd1024;
    idx = off[18:2];
    low = 0;
    write_phase = wr;
    read_phase  = rd && !wr;
    wr_en = wr; rd_en = rd; address = a; write_data = d;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready) break;
      low++;
      if (k >= 1 && k <= 2*W) begin
        half = (k - 1) / W;
        pos  = (k - 1) % W;
        chk({tag, "_addr"}, 32'(sram_addr), 32'({idx, half[0]}));
        chk({tag, "_we_n"}, 32'(sram_we_n), (wr && pos != W-1) ? 32'd0 : 32'd1);
        if (wr) chk({tag, "_dq"}, 32'(sram_dq), (half != 0) ? 32'(d[31:16]) : 32'(d[15:0]));
      end
      @(posedge clk); #1;
      if (!hold) begin
        wr_en = 1'b0; rd_en = 1'b0; address = ~a; write_data = ~d;
      end
    end
    chk({tag, "_lat"}, 32'(low), 32'(2*W + 1));
    chk({tag, "_rdata"}, read_data, exp_rd);
    chk({tag, "_done_we_n"}, 32'(sram_we_n), 32'd1);
    @(posedge clk); #1;
    write_phase = 1'b0;
    read_phase  = 1'b0;
  endtask

  task automatic access1(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd, input string tag);
    int          low;
    logic [31:0] off;
    logic [16:0] idx;
    off = a - 32'd1024;
    idx = off[18:2];
    low = 0;
    read_phase1 = !wr;
    wr_en1 = wr; rd_en1 = !wr; address1 = a; write_data1 = d;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready1) break;
      low++;
      if (k >= 1 && k <= 2) begin
        chk({tag, "_addr"}, 32'(sram_addr1), 32'({idx, k == 2}));
        chk({tag, "_we_n"}, 32'(sram_we_n1), 32'd1);
        if (wr) chk({tag, "_dq"}, 32'(sram_dq1), (k == 2) ? 32'(d[31:16]) : 32'(d[15:0]));
      end
      @(posedge clk); #1;
      wr_en1 = 1'b0; rd_en1 = 1'b0; address1 = ~a; write_data1 = ~d;
    end
    chk({tag, "_lat"}, 32'(low), 32'd3);
    chk({tag, "_rdata"}, read_data1, exp_rd);
    @(posedge clk); #1;
    read_phase1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
    wr_en1 = 1'b0; rd_en1 = 1'b0; address1 = '0; write_data1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_rdata", read_data, 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_dq", 32'(sram_dq), 32'd0);
    chk("rst_rdata1", read_data1, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_ready", 32'(ready), 32'd1);
      chk("idle_we_n", 32'(sram_we_n), 32'd1);
      chk("idle_dq", 32'(sram_dq), 32'd0);
      @(posedge clk); #1;
    end

    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0, 32'h0, "wr_deadbeef");
    chk("mem0", 32'(mem[0]), 32'h0000BEEF);
    chk("mem1", 32'(mem[1]), 32'h0000DEAD);
    access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, 32'hDEADBEEF, "rd_1024");

    access(1'b1, 1'b0, 32'd1028, 32'h12345678, 1'b0, 32'hDEADBEEF, "wr_1028");
    chk("mem2_a", 32'(mem[2]), 32'h00005678);
    chk("mem3_a", 32'(mem[3]), 32'h00001234);
    access(1'b1, 1'b0, 32'd1031, 32'h9ABCDEF0, 1'b0, 32'hDEADBEEF, "wr_1031");
    chk("mem2_b", 32'(mem[2]), 32'h0000DEF0);
    chk("mem3_b", 32'(mem[3]), 32'h00009ABC);
    access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, 32'hDEADBEEF, "rd_1024_again");
    access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, 32'h9ABCDEF0, "rd_1028");

    // Address below the base wraps to the top word index (half-words 0x3FFFE/0x3FFFF).
    access(1'b1, 1'b0, 32'd1020, 32'h0BADCAFE, 1'b0, 32'h9ABCDEF0, "wr_wrap");
    chk("mem_fe", 32'(mem[8'hFE]), 32'h0000CAFE);
    chk("mem_ff", 32'(mem[8'hFF]), 32'h00000BAD);

    access(1'b1, 1'b1, 32'd1032, 32'hA5A55A5A, 1'b1, 32'h9ABCDEF0, "prio");
    write_phase = 1'b1;
    @(negedge clk);
    chk("hold_ready_idle", 32'(ready), 32'd0);
    chk("hold_addr_idle", 32'(sram_addr), 32'd0);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready) break;
      @(posedge clk); #1;
    end
    chk("hold_second_done", 32'(ready), 32'd1);
    @(posedge clk); #1;
    write_phase = 1'b0;
    chk("prio_rdata", read_data, 32'h9ABCDEF0);
    chk("mem4", 32'(mem[4]), 32'h00005A5A);
    chk("mem5", 32'(mem[5]), 32'h0000A5A5);

    access(1'b1, 1'b0, 32'd1040, 32'h77776666, 1'b0, 32'h9ABCDEF0, "wr_1040");

    // Reset lands in the second LOW cycle: low half already strobed, high half never.
    write_phase = 1'b1;
    wr_en = 1'b1; address = 32'd1040; write_data = 32'hCAFEF00D;
    @(posedge clk); #1;
    wr_en = 1'b0;
    @(negedge clk);
    chk("abort_low0_we_n", 32'(sram_we_n), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    write_phase = 1'b0;
    @(negedge clk);
    chk("abort_we_n", 32'(sram_we_n), 32'd1);
    chk("abort_dq", 32'(sram_dq), 32'd0);
    chk("abort_rdata", read_data, 32'd0);
    chk("abort_addr", 32'(sram_addr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_mem9", 32'(mem[9]), 32'h00007777);
    chk("abort_mem8", 32'(mem[8]), 32'h0000F00D);
    @(posedge clk); #1;
    access(1'b0, 1'b1, 32'd1040, 32'h0, 1'b0, 32'h7777F00D, "rd_after_rst");

    access1(1'b1, 32'd1024, 32'hDEADBEEF, 32'h0, "w1_wr");
    access1(1'b0, 32'd1024, 32'h0, 32'hA001A000, "w1_rd_1024");
    access1(1'b0, 32'd1028, 32'h0, 32'hA003A002, "w1_rd_1028");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, SRAM cycles held per half-word access, legal range 1..15.
REQ-002 Parameter BASE_ADDR, default 32'd1024, byte address that maps to SRAM word 0.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 wr_en  input  1  MEM-stage write request.
REQ-006 rd_en  input  1  MEM-stage read request.
REQ-007 address  input  32  byte address of the request.
REQ-008 write_data  input  32  word to store.
REQ-009 read_data  output  32  last word read.
REQ-010 ready  output  1  high = no access pending; low freezes the pipeline.
REQ-011 sram_dq  inout  16  SRAM data bus.
REQ-012 sram_addr  output  18  SRAM half-word address.
REQ-013 sram_we_n  output  1  SRAM write strobe, active-low.

Function
REQ-014 The block SHALL use states IDLE, LOW, HIGH, DONE.
REQ-015 IDLE: with wr_en or rd_en high, the block SHALL drive ready low combinationally in that same cycle, latch address, write_data and op type, and go to LOW.
REQ-016 If wr_en and rd_en are both high, the block SHALL perform a write.
REQ-017 Word index SHALL be (address - BASE_ADDR)[18:2], 17 bits, wrapping modulo 2^17; address[1:0] SHALL be ignored.
REQ-018 LOW SHALL last exactly WAIT_CYCLES cycles with sram_addr = {index,1'b0}; HIGH SHALL then last WAIT_CYCLES cycles with sram_addr = {index,1'b1}.
REQ-019 Write: during LOW/HIGH the block SHALL drive sram_dq with write_data[15:0]/[31:16] and hold sram_we_n low for all cycles of each half except the last, where it SHALL return high with data still driven.
REQ-020 Read: sram_we_n SHALL stay high, sram_dq SHALL be high-Z, and sram_dq SHALL be sampled on the last cycle of LOW into bits [15:0] and of HIGH into bits [31:16].
REQ-021 read_data SHALL update only on entry to DONE after a read and SHALL hold otherwise, including across writes.
REQ-022 DONE SHALL last one cycle with ready high, then go to IDLE unconditionally; a request present during DONE SHALL NOT start an access.
REQ-023 ready SHALL be low in LOW and HIGH, and high in DONE and in IDLE with no request.
REQ-024 Latency: request seen in cycle 0 -> ready low cycles 0..2*WAIT_CYCLES, high in cycle 2*WAIT_CYCLES+1.
REQ-025 Changes on address/write_data/rd_en/wr_en after acceptance SHALL NOT affect the access in flight.
REQ-026 Outside LOW/HIGH of a write, sram_dq SHALL be high-Z and sram_we_n high.
REQ-027 A wait counter SHALL count 0..WAIT_CYCLES-1 per half and reset to 0 on each state change.

Reset
REQ-028 With rst high at a clock edge, the block SHALL enter IDLE, clear the wait counter, and set read_data 0, sram_addr 0, sram_we_n 1, sram_dq high-Z.
REQ-029 Reset mid-access SHALL abort it without completing the remaining SRAM half; ready SHALL be high in the first cycle after reset if no request is present.
REQ-030 Once reset has been released, the block SHALL require no further initialisation before accepting a request.

Verification
REQ-031 Idle: rd_en=wr_en=0 for 20 cycles -> ready=1, sram_we_n=1, sram_dq=Z throughout.
REQ-032 Write then read, WAIT_CYCLES=2: write 0xDEADBEEF to 1024 -> SRAM[0]=0xBEEF, SRAM[1]=0xDEAD, ready low 5 cycles; read 1024 -> read_data=0xDEADBEEF in the DONE cycle.
REQ-033 Address mapping: write 0x12345678 to 1028 -> SRAM[2]=0x5678, SRAM[3]=0x1234; address 1031 -> same half-words; read 1024 -> still 0xDEADBEEF.
REQ-034 Priority and hold: rd_en=wr_en=1 at 1032 with data 0xA5A5_5A5A -> write occurs and read_data is unchanged; request held through DONE -> second access starts only after IDLE.
REQ-035 Reset mid-write: assert rst in the 2nd LOW cycle of a write of 0xCAFEF00D to 1040 -> next cycle sram_we_n=1, sram_dq=Z, read_data=0; SRAM[9] unchanged; ready=1 after rst drops.
REQ-036 WAIT_CYCLES=1 rerun of REQ-032 -> ready low exactly 3 cycles per access.
